forward_unit: RTL

- Hazard/forwarding controller feeding the decode stage's six operand bypass muxes (select code 0 = regfile, 1 = E, 2 = M, 3 = M2, 4 = M3, 5 = M4, 6 = M5).
- Keeps a 6-deep shadow pipeline (E..M5) of in-flight register writes and the stage at which each result becomes valid.
- Per decode-stage source it emits the youngest ready producer's code, or raises stall when the youngest producer's data is not yet available.

---
 rtl/forward_unit_pkg.sv | 35 +++
 rtl/fwd_lookup.sv | 42 ++++
 rtl/forward_unit.sv | 96 +++++++++
 3 files changed

// File: rtl/forward_unit_pkg.sv
// Shared types and constants for the decode-stage forwarding/hazard unit.
//   fwd_sel_t       : bypass mux select code (0 = regfile, 1..6 = E..M5)
//   shadow_entry_t  : one in-flight register write {valid, dest, ready stage}
//   LAT_*           : common result-ready stage indices
package forward_unit_pkg;

    localparam int unsigned REG_W = 6;
    localparam int unsigned LAT_W = 3;

    typedef logic [2:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REG = 3'd0;
    localparam fwd_sel_t FWD_E   = 3'd1;
    localparam fwd_sel_t FWD_M   = 3'd2;
    localparam fwd_sel_t FWD_M2  = 3'd3;
    localparam fwd_sel_t FWD_M3  = 3'd4;
    localparam fwd_sel_t FWD_M4  = 3'd5;
    localparam fwd_sel_t FWD_M5  = 3'd6;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
        logic [LAT_W-1:0] lat;
    } shadow_entry_t;

    localparam logic [LAT_W-1:0] LAT_ALU  = 3'd0;
    localparam logic [LAT_W-1:0] LAT_LOAD = 3'd2;
    localparam logic [LAT_W-1:0] LAT_FPU  = 3'd5;

    // Stage index s (0 = E) maps to bypass code s+1.
    function automatic fwd_sel_t stage_code(input int s);
        return fwd_sel_t'(s + 1);
    endfunction

endpackage

// File: rtl/fwd_lookup.sv
// Per-source bypass lookup against the shadow pipeline.
// Ports:
//   enable    in   source is really read (used & valid); otherwise code 0
//   src       in   source register address (0 = hardwired zero)
//   shadow    in   shadow entries, index 0 = E (youngest) .. NSTAGE-1 = M5
//   sel       out  bypass select code
//   not_ready out  youngest producer's result is not yet available
module fwd_lookup
    import forward_unit_pkg::*;
#(
    parameter int unsigned NSTAGE = 6,
    parameter int unsigned RW     = 6
) (
    input  logic                       enable,
    input  logic [RW-1:0]              src,
    input  shadow_entry_t [NSTAGE-1:0] shadow,
    output fwd_sel_t                   sel,
    output logic                       not_ready
);

    logic hit;

    // Scan youngest-first; only the first match decides, older ones are ignored.
    always_comb begin
        sel       = FWD_REG;
        not_ready = 1'b0;
        hit       = 1'b0;
        if (enable && (src != '0)) begin
            for (int s = 0; s < int'(NSTAGE); s++) begin
                if (!hit && shadow[s].v && (shadow[s].rd == src)) begin
                    hit = 1'b1;
                    if (s >= int'(shadow[s].lat)) begin
                        sel = stage_code(s);
                    end else begin
                        not_ready = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/forward_unit.sv
// Hazard/forwarding controller for the decode stage's six operand bypass muxes.
// Tracks in-flight register writes in a shadow pipeline (E..M5) and, per source,
// selects the youngest ready producer or raises stall.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   hold                pipeline frozen; shadow pipe does not shift
//   flush               decode instruction squashed; bubble enters E
//   d_valid             decode holds a real instruction
//   d_src, d_src_used   six source addresses and their read mask
//   d_regwrite, d_rd    decode instruction's register write and destination
//   d_lat               stage index at which its result becomes valid
//   forward0..forward5  bypass select codes (combinational)
//   stall               decode must hold
module forward_unit
    import forward_unit_pkg::*;
#(
    parameter int unsigned NSTAGE = 6,
    parameter int unsigned RW     = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold,
    input  logic               flush,
    input  logic               d_valid,
    input  logic [5:0][RW-1:0] d_src,
    input  logic [5:0]         d_src_used,
    input  logic               d_regwrite,
    input  logic [RW-1:0]      d_rd,
    input  logic [2:0]         d_lat,
    output logic [2:0]         forward0,
    output logic [2:0]         forward1,
    output logic [2:0]         forward2,
    output logic [2:0]         forward3,
    output logic [2:0]         forward4,
    output logic [2:0]         forward5,
    output logic               stall
);

    localparam int unsigned NSRC = 6;

    shadow_entry_t [NSTAGE-1:0] shadow_q;
    shadow_entry_t [NSTAGE-1:0] shadow_d;
    shadow_entry_t              issue;
    fwd_sel_t                   sel [NSRC];
    logic [NSRC-1:0]            not_ready;

    // A stalled or flushed decode instruction enters E as a bubble; rd 0 is never tracked.
    always_comb begin
        issue.v   = d_valid & d_regwrite & ~stall & ~flush & (d_rd != '0);
        issue.rd  = d_rd;
        issue.lat = d_lat;
    end

    // The entry leaving M5 is dropped: the regfile is written then and reads write-first.
    always_comb begin
        shadow_d = shadow_q;
        if (!hold) begin
            for (int s = int'(NSTAGE) - 1; s >= 1; s--) begin
                shadow_d[s] = shadow_q[s-1];
            end
            shadow_d[0] = issue;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    for (genvar i = 0; i < int'(NSRC); i++) begin : g_src
        fwd_lookup #(
            .NSTAGE (NSTAGE),
            .RW     (RW)
        ) u_lookup (
            .enable    (d_valid & d_src_used[i]),
            .src       (d_src[i]),
            .shadow    (shadow_q),
            .sel       (sel[i]),
            .not_ready (not_ready[i])
        );
    end

    always_comb begin
        forward0 = sel[0];
        forward1 = sel[1];
        forward2 = sel[2];
        forward3 = sel[3];
        forward4 = sel[4];
        forward5 = sel[5];
        stall    = |not_ready;
    end

endmodule
